// File: rtl/ysyx_24110015_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, one outstanding transaction.
// Latency: request accepted in N, mem_req_valid in N+1, response passed through in RSP (>= N+2).
// Backpressure: mem_req_ready=0 holds REQ with stable fields; owner rsp_ready=0 holds RSP.
//
// Ports:
//   i_clk, i_rst                          clock, synchronous active-high reset
//   i_ifu_req_* / o_ifu_req_ready         IFU fetch request (read only)
//   o_ifu_rsp_* / i_ifu_rsp_ready         IFU response
//   i_lsu_req_* / o_lsu_req_ready         LSU load/store request
//   o_lsu_rsp_* / i_lsu_rsp_ready         LSU response (stores also get one)
//   o_mem_req_* / i_mem_req_ready         memory request, fields from registers
//   i_mem_rsp_* / o_mem_rsp_ready         memory response
module ysyx_24110015_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_ifu_req_valid,
    output logic                  o_ifu_req_ready,
    input  logic [ADDR_W-1:0]     i_ifu_req_addr,
    output logic                  o_ifu_rsp_valid,
    input  logic                  i_ifu_rsp_ready,
    output logic [DATA_W-1:0]     o_ifu_rsp_rdata,

    input  logic                  i_lsu_req_valid,
    output logic                  o_lsu_req_ready,
    input  logic [ADDR_W-1:0]     i_lsu_req_addr,
    input  logic                  i_lsu_req_wen,
    input  logic [DATA_W-1:0]     i_lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   i_lsu_req_wmask,
    output logic                  o_lsu_rsp_valid,
    input  logic                  i_lsu_rsp_ready,
    output logic [DATA_W-1:0]     o_lsu_rsp_rdata,

    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_W-1:0]     o_mem_req_addr,
    output logic                  o_mem_req_wen,
    output logic [DATA_W-1:0]     o_mem_req_wdata,
    output logic [DATA_W/8-1:0]   o_mem_req_wmask,
    input  logic                  i_mem_rsp_valid,
    output logic                  o_mem_rsp_ready,
    input  logic [DATA_W-1:0]     i_mem_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_last;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wmask;

    logic w_idle;
    logic w_lsu_win;
    logic w_ifu_win;
    logic w_ifu_fire;
    logic w_lsu_fire;
    logic w_owner_rsp_ready;
    logic w_done;

    // Round-robin on a tie: the unit that was not granted last time wins.
    assign w_lsu_win  = i_lsu_req_valid && (!i_ifu_req_valid || (r_last == OWN_IFU));
    assign w_ifu_win  = i_ifu_req_valid && !w_lsu_win;
    assign w_idle     = (r_state == S_IDLE);
    assign w_ifu_fire = w_idle && w_ifu_win;
    assign w_lsu_fire = w_idle && w_lsu_win;

    assign w_owner_rsp_ready = (r_owner == OWN_LSU) ? i_lsu_rsp_ready : i_ifu_rsp_ready;
    assign w_done = (r_state == S_RSP) && i_mem_rsp_valid && w_owner_rsp_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= OWN_IFU;
            r_last  <= OWN_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            if (w_lsu_fire) begin
                r_owner <= OWN_LSU;
                r_addr  <= i_lsu_req_addr;
                r_wen   <= i_lsu_req_wen;
                r_wdata <= i_lsu_req_wdata;
                r_wmask <= i_lsu_req_wmask;
            end else if (w_ifu_fire) begin
                // Fetches are reads: never let stale store fields leak out.
                r_owner <= OWN_IFU;
                r_addr  <= i_ifu_req_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end
            if (w_done) begin
                r_last <= r_owner;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        o_ifu_req_ready = 1'b0;
        o_lsu_req_ready = 1'b0;
        o_ifu_rsp_valid = 1'b0;
        o_ifu_rsp_rdata = '0;
        o_lsu_rsp_valid = 1'b0;
        o_lsu_rsp_rdata = '0;
        o_mem_req_valid = 1'b0;
        o_mem_rsp_ready = 1'b0;
        o_mem_req_addr  = r_addr;
        o_mem_req_wen   = r_wen;
        o_mem_req_wdata = r_wdata;
        o_mem_req_wmask = r_wmask;

        case (r_state)
            S_IDLE: begin
                o_ifu_req_ready = w_ifu_win;
                o_lsu_req_ready = w_lsu_win;
                if (w_ifu_fire || w_lsu_fire) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_next = S_RSP;
                end
            end
            S_RSP: begin
                o_mem_rsp_ready = w_owner_rsp_ready;
                if (r_owner == OWN_LSU) begin
                    o_lsu_rsp_valid = i_mem_rsp_valid;
                    o_lsu_rsp_rdata = i_mem_rsp_rdata;
                end else begin
                    o_ifu_rsp_valid = i_mem_rsp_valid;
                    o_ifu_rsp_rdata = i_mem_rsp_rdata;
                end
                if (w_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // While reset is held every output shows its reset value, even before
        // the first edge clears the registers, so nothing leaks mid-reset.
        if (i_rst) begin
            w_next          = S_IDLE;
            o_ifu_req_ready = 1'b0;
            o_lsu_req_ready = 1'b0;
            o_ifu_rsp_valid = 1'b0;
            o_ifu_rsp_rdata = '0;
            o_lsu_rsp_valid = 1'b0;
            o_lsu_rsp_rdata = '0;
            o_mem_req_valid = 1'b0;
            o_mem_rsp_ready = 1'b0;
            o_mem_req_addr  = '0;
            o_mem_req_wen   = 1'b0;
            o_mem_req_wdata = '0;
            o_mem_req_wmask = '0;
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
module tb_ysyx_24110015_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_addr, ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic [3:0]  mem_req_wmask;

    int checks = 0;
    int errors = 0;

    ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ifu_req_valid(ifu_req_valid), .o_ifu_req_ready(ifu_req_ready),
        .i_ifu_req_addr(ifu_req_addr),
        .o_ifu_rsp_valid(ifu_rsp_valid), .i_ifu_rsp_ready(ifu_rsp_ready),
        .o_ifu_rsp_rdata(ifu_rsp_rdata),
        .i_lsu_req_valid(lsu_req_valid), .o_lsu_req_ready(lsu_req_ready),
        .i_lsu_req_addr(lsu_req_addr), .i_lsu_req_wen(lsu_req_wen),
        .i_lsu_req_wdata(lsu_req_wdata), .i_lsu_req_wmask(lsu_req_wmask),
        .o_lsu_rsp_valid(lsu_rsp_valid), .i_lsu_rsp_ready(lsu_rsp_ready),
        .o_lsu_rsp_rdata(lsu_rsp_rdata),
        .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
        .o_mem_req_addr(mem_req_addr), .o_mem_req_wen(mem_req_wen),
        .o_mem_req_wdata(mem_req_wdata), .o_mem_req_wmask(mem_req_wmask),
        .i_mem_rsp_valid(mem_rsp_valid), .o_mem_rsp_ready(mem_rsp_ready),
        .i_mem_rsp_rdata(mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;  logic [31:0] ia;  logic irr;
        logic        lv;  logic [31:0] la;  logic lw;  logic [31:0] lwd;  logic [3:0] lwm;  logic lrr;
        logic        mrr; logic mv;  logic [31:0] md;
    } in_t;

    typedef struct {
        logic        iqr; logic lqr;
        logic        irv; logic [31:0] ird;
        logic        lrv; logic [31:0] lrd;
        logic        mv;  logic [31:0] ma;  logic mw;  logic [31:0] mwd;  logic [3:0] mwm;
        logic        mrr;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t mi(logic r, logic iv, logic [31:0] ia, logic irr,
                               logic lv, logic [31:0] la, logic lw, logic [31:0] lwd,
                               logic [3:0] lwm, logic lrr, logic mrr, logic mv, logic [31:0] md);
        in_t x;
        x.rst = r; x.iv = iv; x.ia = ia; x.irr = irr;
        x.lv = lv; x.la = la; x.lw = lw; x.lwd = lwd; x.lwm = lwm; x.lrr = lrr;
        x.mrr = mrr; x.mv = mv; x.md = md;
        return x;
    endfunction

    function automatic exp_t me(logic iqr, logic lqr, logic irv, logic [31:0] ird,
                                logic lrv, logic [31:0] lrd, logic mv, logic [31:0] ma,
                                logic mw, logic [31:0] mwd, logic [3:0] mwm, logic mrr);
        exp_t x;
        x.iqr = iqr; x.lqr = lqr; x.irv = irv; x.ird = ird; x.lrv = lrv; x.lrd = lrd;
        x.mv = mv; x.ma = ma; x.mw = mw; x.mwd = mwd; x.mwm = mwm; x.mrr = mrr;
        return x;
    endfunction

    function automatic in_t idle_in();
        return mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t x);
        rst = x.rst;
        ifu_req_valid = x.iv; ifu_req_addr = x.ia; ifu_rsp_ready = x.irr;
        lsu_req_valid = x.lv; lsu_req_addr = x.la; lsu_req_wen = x.lw;
        lsu_req_wdata = x.lwd; lsu_req_wmask = x.lwm; lsu_rsp_ready = x.lrr;
        mem_req_ready = x.mrr; mem_rsp_valid = x.mv; mem_rsp_rdata = x.md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   ng;
        logic g_lsu [4];
        int   g_cyc [4];
        in_t  x;

        drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset and idle
        tbl.push_back('{mi(1,0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mi(1,0,0,0,0,0,0,0,0,0,0,0,0), me(0,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{idle_in(),                     me(0,0,0,0,0,0,0,0,0,0,0,0)});
        // Single IFU fetch, minimum latency
        tbl.push_back('{mi(0,1,32'h80000000,1,0,0,0,0,0,0,1,0,0), me(1,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,1,0,0,0,0,0,0,1,0,0), me(0,0,0,0,0,0,1,32'h80000000,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,1,0,0,0,0,0,0,1,1,32'h00000413), me(0,0,1,32'h00000413,0,0,0,32'h80000000,0,0,0,1)});
        tbl.push_back('{idle_in(), me(0,0,0,0,0,0,0,32'h80000000,0,0,0,0)});
        // LSU store
        tbl.push_back('{mi(0,0,0,0,1,32'h80001000,1,32'hDEADBEEF,4'hF,1,0,0,0), me(0,1,0,0,0,0,0,32'h80000000,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,1,1,0,0), me(0,0,0,0,0,0,1,32'h80001000,1,32'hDEADBEEF,4'hF,0)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,1,1,1,32'h12345678), me(0,0,0,0,1,32'h12345678,0,32'h80001000,1,32'hDEADBEEF,4'hF,1)});
        tbl.push_back('{idle_in(), me(0,0,0,0,0,0,0,32'h80001000,1,32'hDEADBEEF,4'hF,0)});
        // Spurious memory response while idle, then a fetch must still be accepted
        tbl.push_back('{mi(0,0,0,1,0,0,0,0,0,1,0,1,32'hAAAA5555), me(0,0,0,0,0,0,0,32'h80001000,1,32'hDEADBEEF,4'hF,0)});
        tbl.push_back('{mi(0,1,32'h80000004,1,0,0,0,0,0,1,0,1,32'hAAAA5555), me(1,0,0,0,0,0,0,32'h80001000,1,32'hDEADBEEF,4'hF,0)});
        tbl.push_back('{mi(0,0,0,1,0,0,0,0,0,0,1,0,0), me(0,0,0,0,0,0,1,32'h80000004,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,1,0,0,0,0,0,0,1,1,32'h00100073), me(0,0,1,32'h00100073,0,0,0,32'h80000004,0,0,0,1)});
        tbl.push_back('{idle_in(), me(0,0,0,0,0,0,0,32'h80000004,0,0,0,0)});
        // LSU load, reset while in RSP, then a normal fetch
        tbl.push_back('{mi(0,0,0,0,1,32'h80002000,0,0,0,0,0,0,0), me(0,1,0,0,0,0,0,32'h80000004,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,0,1,0,0), me(0,0,0,0,0,0,1,32'h80002000,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,0,0,1,32'hCAFEF00D), me(0,0,0,0,1,32'hCAFEF00D,0,32'h80002000,0,0,0,0)});
        tbl.push_back('{mi(1,0,0,0,0,0,0,0,0,0,0,1,32'hCAFEF00D), me(0,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,1,0,1,32'hCAFEF00D), me(0,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mi(0,1,32'h80000008,1,0,0,0,0,0,0,1,0,0), me(1,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,1,0,0,0,0,0,0,1,0,0), me(0,0,0,0,0,0,1,32'h80000008,0,0,0,0)});
        tbl.push_back('{mi(0,0,0,1,0,0,0,0,0,0,1,1,32'h11112222), me(0,0,1,32'h11112222,0,0,0,32'h80000008,0,0,0,1)});
        tbl.push_back('{idle_in(), me(0,0,0,0,0,0,0,32'h80000008,0,0,0,0)});

        tick();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].i);
            @(negedge clk);
            chk($sformatf("r%0d_ifu_req_ready", i), {31'd0, ifu_req_ready}, {31'd0, tbl[i].e.iqr});
            chk($sformatf("r%0d_lsu_req_ready", i), {31'd0, lsu_req_ready}, {31'd0, tbl[i].e.lqr});
            chk($sformatf("r%0d_ifu_rsp_valid", i), {31'd0, ifu_rsp_valid}, {31'd0, tbl[i].e.irv});
            chk($sformatf("r%0d_ifu_rsp_rdata", i), ifu_rsp_rdata, tbl[i].e.ird);
            chk($sformatf("r%0d_lsu_rsp_valid", i), {31'd0, lsu_rsp_valid}, {31'd0, tbl[i].e.lrv});
            chk($sformatf("r%0d_lsu_rsp_rdata", i), lsu_rsp_rdata, tbl[i].e.lrd);
            chk($sformatf("r%0d_mem_req_valid", i), {31'd0, mem_req_valid}, {31'd0, tbl[i].e.mv});
            chk($sformatf("r%0d_mem_req_addr", i), mem_req_addr, tbl[i].e.ma);
            chk($sformatf("r%0d_mem_req_wen", i), {31'd0, mem_req_wen}, {31'd0, tbl[i].e.mw});
            chk($sformatf("r%0d_mem_req_wdata", i), mem_req_wdata, tbl[i].e.mwd);
            chk($sformatf("r%0d_mem_req_wmask", i), {28'd0, mem_req_wmask}, {28'd0, tbl[i].e.mwm});
            chk($sformatf("r%0d_mem_rsp_ready", i), {31'd0, mem_rsp_ready}, {31'd0, tbl[i].e.mrr});
            tick();
        end

        // Continuous contention from reset: LSU, IFU, LSU, IFU, one grant every 3 cycles.
        drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mi(0, 1, 32'h80000100, 1, 1, 32'h80000200, 0, 0, 0, 1, 1, 1, 32'h00000055));
        ng = 0;
        for (int cyc = 0; cyc < 30 && ng < 4; cyc++) begin
            @(negedge clk);
            chk($sformatf("cont_c%0d_both_ready", cyc), {31'd0, ifu_req_ready && lsu_req_ready}, 32'd0);
            if (ifu_req_ready || lsu_req_ready) begin
                g_lsu[ng] = lsu_req_ready;
                g_cyc[ng] = cyc;
                ng++;
            end
            tick();
        end
        chk("cont_grant_count", ng, 4);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("cont_g%0d_is_lsu", k), {31'd0, g_lsu[k]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont_g%0d_cycle", k), g_cyc[k], 3 * k);
        end

        // Back-pressure: memory stalls the request, then the IFU stalls the response.
        drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mi(0, 1, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("bp_accept", {31'd0, ifu_req_ready}, 32'd1);
        tick();
        drive(mi(0, 0, 0, 0, 1, 32'h80000300, 1, 32'h01020304, 4'h3, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_req_s%0d_valid", k), {31'd0, mem_req_valid}, 32'd1);
            chk($sformatf("bp_req_s%0d_addr", k), mem_req_addr, 32'h80000010);
            chk($sformatf("bp_req_s%0d_wen", k), {31'd0, mem_req_wen}, 32'd0);
            chk($sformatf("bp_req_s%0d_wmask", k), {28'd0, mem_req_wmask}, 32'd0);
            chk($sformatf("bp_req_s%0d_lsu_ready", k), {31'd0, lsu_req_ready}, 32'd0);
            tick();
        end
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        chk("bp_req_accept_valid", {31'd0, mem_req_valid}, 32'd1);
        tick();
        x = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        drive(x);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_rsp_s%0d_valid", k), {31'd0, ifu_rsp_valid}, 32'd1);
            chk($sformatf("bp_rsp_s%0d_rdata", k), ifu_rsp_rdata, 32'h0BADF00D);
            chk($sformatf("bp_rsp_s%0d_mem_ready", k), {31'd0, mem_rsp_ready}, 32'd0);
            tick();
        end
        x.irr = 1'b1;
        drive(x);
        @(negedge clk);
        chk("bp_rsp_deliver_valid", {31'd0, ifu_rsp_valid}, 32'd1);
        chk("bp_rsp_deliver_mem_ready", {31'd0, mem_rsp_ready}, 32'd1);
        tick();
        @(negedge clk);
        chk("bp_rsp_once_valid", {31'd0, ifu_rsp_valid}, 32'd0);
        chk("bp_rsp_once_mem_ready", {31'd0, mem_rsp_ready}, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_mem_arbiter.md
# ysyx_24110015_mem_arbiter

Two-master, one-slave memory arbiter for the NPC core. It shares the single memory port between the IFU (instruction fetch, read-only) and the LSU (loads and stores). The block replaces direct per-unit memory access with a valid/ready request/response protocol and allows one outstanding transaction at a time. It sits between IFU/LSU and the memory model, which is the DPI-backed pmem or a later AXI bridge.

## Interface
- ADDR_W, 32, address width of all request channels
- DATA_W, 32, data width; write mask is DATA_W/8 bits

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake
- ifu_rsp_rdata  out  DATA_W  fetched instruction word
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_addr  in  ADDR_W  load/store address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wmask  in  DATA_W/8  byte enables for stores
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake (stores also get one response)
- lsu_rsp_rdata  out  DATA_W  load data
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  ADDR_W, 1, DATA_W, DATA_W/8  registered request fields
- mem_rsp_valid / mem_rsp_ready  in / out  1  memory response handshake
- mem_rsp_rdata  in  DATA_W  memory read data

## Operation
- The FSM has three states: IDLE, REQ and RSP. Registers: `owner` (0 = IFU, 1 = LSU), `last` (last owner granted) and the latched request fields.
- Winner selection in IDLE:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to `last` wins (round-robin).
- Ready signals: `ifu_req_ready` and `lsu_req_ready` equal (state==IDLE && winner is that unit). They are never both 1.
- IDLE → REQ on the winner's handshake:
  - Latch addr/wen/wdata/wmask and set `owner`.
  - For an IFU request, force wen=0 and wmask=0.
- REQ:
  - mem_req_valid=1 and mem_req_* driven from registers, stable until accepted.
  - On mem_req_ready, go to RSP.
- RSP:
  - Owner's rsp_valid = mem_rsp_valid. Owner's rsp_rdata = mem_rsp_rdata (combinational pass-through).
  - mem_rsp_ready = owner's rsp_ready.
  - On mem_rsp_valid && mem_rsp_ready: set `last` ← `owner` and go to IDLE.
- The non-owner's rsp_valid is always 0. Its rsp_rdata is 0.
- mem_rsp_valid outside RSP is ignored. mem_rsp_ready is 0 outside RSP.

## Timing
- Reset values: state=IDLE, last=IFU (so the LSU wins the first tie), owner=IFU, latched fields=0.
- Output values under reset: mem_req_valid=0, mem_rsp_ready=0, both rsp_valid=0, both rdata=0, mem_req_* = 0.
- Minimum latency:
  - Request accepted in cycle N → mem_req_valid in N+1.
  - If mem_req_ready=1 in N+1 → RSP from N+2.
  - A response present in N+2 is delivered to the requester in N+2.
  - The next request can be accepted in N+3.
- Back-pressure: mem_req_ready=0 holds REQ indefinitely with fields stable. A requester rsp_ready=0 holds RSP and keeps mem_rsp_ready=0.
- Requests arriving while not IDLE are not accepted; their ready stays 0. A requester must hold valid and fields until ready.
- A requester that drops valid in IDLE before the handshake loses nothing; arbitration re-evaluates each cycle.
- rst asserted mid-transaction: back to IDLE next edge and the transaction is dropped. The memory side is reset by the same rst. No response is delivered afterwards.
- Throughput: at most one transaction per 3 cycles. Under continuous contention, grants strictly alternate.

## Test plan
- Single IFU fetch: ifu_req addr=0x80000000 with mem ready always 1 and rdata=0x00000413 two cycles later → ifu_rsp_valid with 0x00000413 at cycle N+2, mem_req_wen=0, wmask=0, lsu_rsp_valid stays 0.
- LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF → mem_req carries exactly those fields with wen=1. One lsu_rsp_valid pulse follows, then IDLE.
- Simultaneous requests from reset, both held continuously for 4 transactions → grant order LSU, IFU, LSU, IFU; never both req_ready=1.
- Back-pressure: mem_req_ready low for 5 cycles, then ifu_rsp_ready low for 3 cycles → mem_req_* stable across the stall. Response held and delivered once; mem_rsp_ready mirrors ifu_rsp_ready.
- Reset in RSP state with an LSU load outstanding → next cycle IDLE with all outputs at reset values. A new IFU request is then accepted normally.
- Spurious mem_rsp_valid while IDLE → no rsp_valid on either requester; state unchanged.
